// File: rtl/dma_pkg.sv
// Shared DMA descriptor definitions: field widths, channel count and the
// packed command descriptor stored in the command queue.
package dma_pkg;

  localparam int DMA_SIZE_W = 8;
  localparam int DMA_ADDR_W = 8;
  localparam int DMA_NUM_CH = 2;

  // One queued transfer request. Field order is {ch, src, dst, size}.
  typedef struct packed {
    logic                  ch;
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_SIZE_W-1:0] size;
  } dma_desc_t;

  function automatic dma_desc_t dma_pack(
    input logic                  ch,
    input logic [DMA_ADDR_W-1:0] src,
    input logic [DMA_ADDR_W-1:0] dst,
    input logic [DMA_SIZE_W-1:0] size
  );
    dma_desc_t d;
    d.ch   = ch;
    d.src  = src;
    d.dst  = dst;
    d.size = size;
    return d;
  endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous descriptor FIFO for the DMA command queue. DEPTH must be a
// power of two (>= 2) so the pointers wrap naturally. The head entry is
// presented combinationally on rdata; level counts stored entries.
module dma_cmd_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  dma_desc_t                wdata,
  input  logic                     pop,
  output dma_desc_t                rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  dma_desc_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; push and pop together leave level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_cmd_queue.sv
// DMA command queue: accepts descriptors, drops zero-size ones (counted in
// drop_cnt), and dispatches the FIFO head strictly in order to one of two
// DMA channels once that channel is idle. Busy clears on a rising edge of
// the channel's done input.
// Optional feature: define DMA_CMDQ_IRQ_EN to add the irq output, a
// one-cycle pulse when the queue has fully drained after activity.
// ADDR_WIDTH is expected to equal dma_pkg::DMA_ADDR_W (the descriptor
// field width).
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DMA_ADDR_W,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_ch,
  input  logic [ADDR_WIDTH-1:0]   cmd_src,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst,
  input  logic [DMA_SIZE_W-1:0]   cmd_size,
  output logic                    ch0_start,
  output logic                    ch1_start,
  output logic [ADDR_WIDTH-1:0]   ch0_src,
  output logic [ADDR_WIDTH-1:0]   ch0_dst,
  output logic [ADDR_WIDTH-1:0]   ch1_src,
  output logic [ADDR_WIDTH-1:0]   ch1_dst,
  output logic [DMA_SIZE_W-1:0]   ch0_size,
  output logic [DMA_SIZE_W-1:0]   ch1_size,
  input  logic                    ch0_done,
  input  logic                    ch1_done,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DMA_NUM_CH-1:0]   ch_busy,
  output logic [7:0]              drop_cnt
`ifdef DMA_CMDQ_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                  accept;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic                  head_valid;
  dma_desc_t             wr_desc;
  dma_desc_t             head;
  logic [DMA_NUM_CH-1:0] done_in;
  logic [DMA_NUM_CH-1:0] done_q;
  logic [DMA_NUM_CH-1:0] done_rise;

  // Ready depends only on registered occupancy; no bypass when full.
  assign cmd_ready  = !rst && (level != LW'(DEPTH));
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && (cmd_size != '0);
  assign drop       = accept && (cmd_size == '0);
  assign wr_desc    = dma_pack(cmd_ch, cmd_src, cmd_dst, cmd_size);

  // Head-of-line: only the head may go, and only if its channel is idle.
  assign head_valid = (level != '0);
  assign pop        = head_valid && !ch_busy[head.ch];

  // Done is edge-detected so a done held high does not re-clear busy later.
  assign done_in    = {ch1_done, ch0_done};
  assign done_rise  = done_in & ~done_q & ch_busy;

  dma_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_desc),
    .pop   (pop),
    .rdata (head),
    .level (level)
  );

  // Previous done levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) done_q <= '0;
    else     done_q <= done_in;
  end

  // Dispatch: register the head descriptor into its channel and pulse start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch0_start <= 1'b0;
      ch1_start <= 1'b0;
      ch0_src   <= '0;
      ch0_dst   <= '0;
      ch0_size  <= '0;
      ch1_src   <= '0;
      ch1_dst   <= '0;
      ch1_size  <= '0;
    end else begin
      ch0_start <= 1'b0;
      ch1_start <= 1'b0;
      if (pop) begin
        if (head.ch == 1'b0) begin
          ch0_start <= 1'b1;
          ch0_src   <= head.src;
          ch0_dst   <= head.dst;
          ch0_size  <= head.size;
        end else begin
          ch1_start <= 1'b1;
          ch1_src   <= head.src;
          ch1_dst   <= head.dst;
          ch1_size  <= head.size;
        end
      end
    end
  end

  // Busy flags: set on dispatch, cleared on done rise. Set only happens when
  // idle and clear only when busy, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_busy <= '0;
    end else begin
      for (int i = 0; i < DMA_NUM_CH; i++) begin
        if (pop && (int'(head.ch) == i)) ch_busy[i] <= 1'b1;
        else if (done_rise[i])           ch_busy[i] <= 1'b0;
      end
    end
  end

  // Zero-size commands are consumed but never stored; count them, saturating.
  always_ff @(posedge clk) begin
    if (rst)                              drop_cnt <= '0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
  end

`ifdef DMA_CMDQ_IRQ_EN
  logic act_pend;
  logic idle;

  assign idle = (level == '0) && (ch_busy == '0);

  // Arm on every stored command; fire once when queue and channels are idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (push) begin
        act_pend <= 1'b1;
      end else if (idle && act_pend) begin
        irq      <= 1'b1;
        act_pend <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed bench for dma_cmd_queue. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point, before new stimulus.
module tb_dma_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ch;
  logic [7:0] cmd_src;
  logic [7:0] cmd_dst;
  logic [7:0] cmd_size;
  logic       ch0_start;
  logic       ch1_start;
  logic [7:0] ch0_src;
  logic [7:0] ch0_dst;
  logic [7:0] ch1_src;
  logic [7:0] ch1_dst;
  logic [7:0] ch0_size;
  logic [7:0] ch1_size;
  logic       ch0_done;
  logic       ch1_done;
  logic [2:0] level;
  logic [1:0] ch_busy;
  logic [7:0] drop_cnt;
`ifdef DMA_CMDQ_IRQ_EN
  logic       irq;
`endif

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0;

  always #5 clk = ~clk;

  dma_cmd_queue #(
    .ADDR_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_size  (cmd_size),
    .ch0_start (ch0_start),
    .ch1_start (ch1_start),
    .ch0_src   (ch0_src),
    .ch0_dst   (ch0_dst),
    .ch1_src   (ch1_src),
    .ch1_dst   (ch1_dst),
    .ch0_size  (ch0_size),
    .ch1_size  (ch1_size),
    .ch0_done  (ch0_done),
    .ch1_done  (ch1_done),
    .level     (level),
    .ch_busy   (ch_busy),
    .drop_cnt  (drop_cnt)
`ifdef DMA_CMDQ_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
`ifdef DMA_CMDQ_IRQ_EN
    if (irq) irq_cnt++;
`endif
  endtask

  task automatic set_cmd(input logic ch, input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] size);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_size  = size;
  endtask

  task automatic push_cmd(input logic ch, input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] size);
    set_cmd(ch, src, dst, size);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Toggle done on each busy channel until everything has drained (bounded).
  task automatic drain(input string tag);
    int n = 0;
    while (((level != 0) || (ch_busy != 0)) && (n < 60)) begin
      ch0_done = ch_busy[0] && !ch0_done;
      ch1_done = ch_busy[1] && !ch1_done;
      tick();
      n++;
    end
    ch0_done = 1'b0;
    ch1_done = 1'b0;
    chk({tag, "_drained"}, {level, ch_busy}, 0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_size = '0; ch0_done = 1'b0; ch1_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_level", level, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_start", {ch0_start, ch1_start}, 0);
    chk("rst_fields", {ch0_src, ch0_dst, ch0_size, ch1_size}, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready_rel", cmd_ready, 1);

    // Single command, one cycle latency, level-style done
    push_cmd(1'b0, 8'd10, 8'd100, 8'd2);
    chk("t1_level", level, 1);
    chk("t1_nostart", ch0_start, 0);
    tick();
    chk("t1_start", ch0_start, 1);
    chk("t1_fields", {ch0_src, ch0_dst, ch0_size}, {8'd10, 8'd100, 8'd2});
    chk("t1_busy", ch_busy, 2'b01);
    chk("t1_level0", level, 0);
    tick();
    chk("t1_pulse", ch0_start, 0);
    chk("t1_hold", ch0_src, 10);
    ch0_done = 1'b1;
    tick();
    chk("t1_done", ch_busy, 0);
    tick(); tick();
    chk("t1_lvl_done", ch_busy, 0);
    ch0_done = 1'b0;
    drain("t1");

    // Full FIFO behind busy ch1
    push_cmd(1'b1, 8'h01, 8'h02, 8'h03);
    tick();
    chk("t2_busy", ch_busy, 2'b10);
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'h20 + 8'(i), 8'h40, 8'h04 + 8'(i));
    chk("t2_full", level, 4);
    chk("t2_notready", cmd_ready, 0);
    set_cmd(1'b1, 8'h24, 8'h40, 8'h08);
    tick();
    chk("t2_stall", level, 4);
    ch1_done = 1'b1;
    tick();
    ch1_done = 1'b0;
    chk("t2_clear", ch_busy, 0);
    chk("t2_stall2", level, 4);
    tick();
    chk("t2_disp", {ch1_start, ch1_src, ch1_size}, {1'b1, 8'h20, 8'h04});
    chk("t2_level3", level, 3);
    chk("t2_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_fifth", level, 4);
    drain("t2");

    // Head-of-line blocking, then other channel while one is busy
    push_cmd(1'b0, 8'h30, 8'h40, 8'h10);
    push_cmd(1'b0, 8'h31, 8'h41, 8'h11);
    push_cmd(1'b1, 8'h32, 8'h42, 8'h12);
    tick(); tick(); tick();
    chk("t3_blocked", {level, ch_busy, ch1_start}, {3'd2, 2'b01, 1'b0});
    ch0_done = 1'b1;
    tick();
    ch0_done = 1'b0;
    chk("t3_clear", ch_busy, 0);
    tick();
    chk("t3_ch0", {ch0_start, ch0_src, ch_busy, level}, {1'b1, 8'h31, 2'b01, 3'd1});
    tick();
    chk("t3_ch1", {ch1_start, ch1_src, ch1_size, ch_busy, level},
        {1'b1, 8'h32, 8'h12, 2'b11, 3'd0});
    drain("t3");

    // Zero-size drops
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b0, 8'h55, 8'h66, 8'h00);
      chk("t4_nostart", {ch0_start, ch1_start}, 0);
    end
    tick();
    chk("t4_drop", drop_cnt, 3);
    chk("t4_level", {level, ch_busy, ch0_start, ch1_start}, 0);

    // Simultaneous push and pop at level 2
    push_cmd(1'b0, 8'h50, 8'h60, 8'h01);
    push_cmd(1'b0, 8'h51, 8'h61, 8'h21);
    push_cmd(1'b0, 8'h52, 8'h62, 8'h22);
    chk("t5_level2", level, 2);
    ch0_done = 1'b1;
    tick();
    ch0_done = 1'b0;
    chk("t5_clear", {ch_busy, level}, {2'b00, 3'd2});
    push_cmd(1'b0, 8'h53, 8'h63, 8'h23);
    chk("t5_pushpop", {level, ch0_start, ch0_src}, {3'd2, 1'b1, 8'h51});
    ch0_done = 1'b1; tick(); ch0_done = 1'b0; tick();
    chk("t5_next", {ch0_start, ch0_src, level}, {1'b1, 8'h52, 3'd1});
    ch0_done = 1'b1; tick(); ch0_done = 1'b0; tick();
    chk("t5_last", {ch0_start, ch0_src, ch0_size, level}, {1'b1, 8'h53, 8'h23, 3'd0});
    drain("t5");

    // drop_cnt saturation
    cmd_valid = 1'b1; cmd_size = 8'h00;
    for (int i = 0; i < 260; i++) tick();
    cmd_valid = 1'b0;
    chk("t6_sat", drop_cnt, 255);

    // Reset mid-operation
    push_cmd(1'b0, 8'h70, 8'h80, 8'h01);
    push_cmd(1'b0, 8'h71, 8'h81, 8'h02);
    push_cmd(1'b0, 8'h72, 8'h82, 8'h03);
    push_cmd(1'b0, 8'h73, 8'h83, 8'h04);
    chk("t7_pre", {level, ch_busy}, {3'd3, 2'b01});
    rst = 1'b1;
    tick();
    chk("t7_rst", {level, ch_busy, drop_cnt, ch0_start, ch1_start}, 0);
    chk("t7_fields", {ch0_src, ch0_dst, ch0_size, cmd_ready}, 0);
`ifdef DMA_CMDQ_IRQ_EN
    chk("t7_irq_rst", irq, 0);
`endif
    rst = 1'b0;
    tick();
    chk("t7_post", {level, ch_busy, ch0_start, ch1_start}, 0);
    irq_cnt = 0;
    push_cmd(1'b0, 8'h90, 8'hA0, 8'h05);
    push_cmd(1'b1, 8'h91, 8'hA1, 8'h06);
    drain("t7");
    tick(); tick();
`ifdef DMA_CMDQ_IRQ_EN
    chk("t7_irq_once", irq_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
